pipe_ctrl_regs: RTL and testbench
=================================

PIPE_CTRL_REGS -- requirements
Module: pipe_ctrl_regs

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  clock; all state changes on rising edge
  rst  in  1  reset, synchronous, active-high
  if_valid  in  1  IF stage holds a valid instruction
  id_en/id_rst, exe_en/exe_rst, mem_en/mem_rst, wb_en/wb_rst  in  1 each  per-stage enable/clear from the pipeline controller
  id_wb_wen  in  1  decoded register-write enable
  id_regw_addr  in  5  decoded write address, already resolved rd/rt/r31
  id_mem_ren, id_mem_wen, id_is_branch  in  1 each  decoded memory-read, memory-write and branch flags
  id_valid, exe_valid, mem_valid, wb_valid  out  1 each  stage valid flags
  regw_addr_exe, regw_addr_mem, regw_addr_wb  out  5  write address per stage
  wb_wen_exe, wb_wen_mem, wb_wen_wb  out  1  qualified write enable per stage
  mem_ren_exe, mem_ren_mem, mem_wen_mem, is_branch_exe, is_branch_mem  out  1  qualified flags
  cycle_cnt, retire_cnt, stall_cnt  out  32 each  performance counters

Function
REQ-002 Stage update priority SHALL be: rst, then X_rst, then X_en, then hold.
REQ-003 A stage clear SHALL load valid=0, address=0 and all flags=0, regardless of X_en.
REQ-004 On X_en=1 without clear, each stage SHALL load from its predecessor: ID from if_valid; EXE from the ID decode inputs and id_valid; MEM from EXE; WB from MEM.
REQ-005 On X_en=0 without clear, the stage SHALL hold all fields.
REQ-006 EXE SHALL latch its write enable as id_wb_wen AND (id_regw_addr != 0); writes to r0 never appear as enabled downstream.
REQ-007 Every 1-bit flag output SHALL equal the stored flag AND the stage valid bit (combinational AND of registered bits).
REQ-008 Each address output SHALL be the stored register value, with no gating.
REQ-009 Latency SHALL be exactly one cycle per enabled stage: decode inputs present at edge N appear on the *_exe outputs after edge N, on *_mem after N+1, and on *_wb after N+2, when no stall occurs.
REQ-010 Load-stall bubble: id_en=0, exe_rst=1 in the same cycle SHALL hold ID and make EXE invalid with all fields zero, while MEM and WB advance.
REQ-011 If X_rst and X_en are both high, the clear SHALL win.
REQ-012 A stage held by X_en=0 SHALL keep its contents even while its predecessor changes.

Reset
REQ-013 On rst=1 at a rising edge, all valid bits, addresses, flags and counters SHALL become 0.
REQ-014 After reset is released, all outputs SHALL read 0 until the first enabled load.
REQ-015 rst asserted mid-operation SHALL discard in-flight entries with no partial update.

Configuration
REQ-016 Macro PIPE_PERF_CNT_EN SHALL control the performance counters.
REQ-017 With PIPE_PERF_CNT_EN defined:
  - cycle_cnt SHALL increment every non-reset cycle.
  - retire_cnt SHALL increment when wb_valid=1 and wb_en=1 and wb_rst=0.
  - stall_cnt SHALL increment when id_en=0 and exe_rst=1.
  - All three counters SHALL saturate at 0xFFFFFFFF.
REQ-018 Without PIPE_PERF_CNT_EN, the three counters SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-019 Reset, then stream: ADDI with wb_wen=1, addr=5, all enables high -> regw_addr_exe=5 and wb_wen_exe=1 after 1 edge, *_mem after 2 edges, wb_wen_wb=1 after 3 edges.
REQ-020 r0 write: id_wb_wen=1, id_regw_addr=0 -> wb_wen_exe=0 and exe_valid=1.
REQ-021 Load stall: LW addr=8 in EXE; next edge with id_en=0, exe_rst=1 -> exe_valid=0 and mem_ren_mem=1, regw_addr_mem=8, and the ID stage is unchanged.
REQ-022 Simultaneous mem_en=1 and mem_rst=1 with a valid EXE entry -> mem_valid=0 and regw_addr_mem=0.
REQ-023 Hold: wb_en=0 for 3 cycles while MEM changes -> WB outputs constant; with the macro defined, retire_cnt unchanged.
REQ-024 With the macro defined, 10 cycles after reset including 2 stall cycles and 4 retirements -> cycle_cnt=10, stall_cnt=2, retire_cnt=4; rst mid-run returns all three to 0.

Source files
------------

// File: rtl/pipe_ctrl_regs.sv
// Pipeline control register chain (ID/EXE/MEM/WB) carrying valid bits, write address and decoded flags.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic        id_en,
  input  logic        id_rst,
  input  logic        exe_en,
  input  logic        exe_rst,
  input  logic        mem_en,
  input  logic        mem_rst,
  input  logic        wb_en,
  input  logic        wb_rst,
  input  logic        id_wb_wen,
  input  logic [4:0]  id_regw_addr,
  input  logic        id_mem_ren,
  input  logic        id_mem_wen,
  input  logic        id_is_branch,
  output logic        id_valid,
  output logic        exe_valid,
  output logic        mem_valid,
  output logic        wb_valid,
  output logic [4:0]  regw_addr_exe,
  output logic [4:0]  regw_addr_mem,
  output logic [4:0]  regw_addr_wb,
  output logic        wb_wen_exe,
  output logic        wb_wen_mem,
  output logic        wb_wen_wb,
  output logic        mem_ren_exe,
  output logic        mem_ren_mem,
  output logic        mem_wen_mem,
  output logic        is_branch_exe,
  output logic        is_branch_mem,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt,
  output logic [31:0] stall_cnt
);

  logic       id_valid_r;
  logic       exe_valid_r, exe_wen_r, exe_ren_r, exe_mwen_r, exe_br_r;
  logic [4:0] exe_addr_r;
  logic       mem_valid_r, mem_wen_r, mem_ren_r, mem_mwen_r, mem_br_r;
  logic [4:0] mem_addr_r;
  logic       wb_valid_r, wb_wen_r;
  logic [4:0] wb_addr_r;

  // ID stage: only the valid bit is tracked here
  always_ff @(posedge clk) begin
    if (rst || id_rst) begin
      id_valid_r <= 1'b0;
    end else if (id_en) begin
      id_valid_r <= if_valid;
    end
  end

  // EXE stage: r0 writes are dropped at capture so they never look enabled downstream
  always_ff @(posedge clk) begin
    if (rst || exe_rst) begin
      exe_valid_r <= 1'b0;
      exe_addr_r  <= 5'd0;
      exe_wen_r   <= 1'b0;
      exe_ren_r   <= 1'b0;
      exe_mwen_r  <= 1'b0;
      exe_br_r    <= 1'b0;
    end else if (exe_en) begin
      exe_valid_r <= id_valid_r;
      exe_addr_r  <= id_regw_addr;
      exe_wen_r   <= id_wb_wen && (id_regw_addr != 5'd0);
      exe_ren_r   <= id_mem_ren;
      exe_mwen_r  <= id_mem_wen;
      exe_br_r    <= id_is_branch;
    end
  end

  // MEM stage
  always_ff @(posedge clk) begin
    if (rst || mem_rst) begin
      mem_valid_r <= 1'b0;
      mem_addr_r  <= 5'd0;
      mem_wen_r   <= 1'b0;
      mem_ren_r   <= 1'b0;
      mem_mwen_r  <= 1'b0;
      mem_br_r    <= 1'b0;
    end else if (mem_en) begin
      mem_valid_r <= exe_valid_r;
      mem_addr_r  <= exe_addr_r;
      mem_wen_r   <= exe_wen_r;
      mem_ren_r   <= exe_ren_r;
      mem_mwen_r  <= exe_mwen_r;
      mem_br_r    <= exe_br_r;
    end
  end

  // WB stage
  always_ff @(posedge clk) begin
    if (rst || wb_rst) begin
      wb_valid_r <= 1'b0;
      wb_addr_r  <= 5'd0;
      wb_wen_r   <= 1'b0;
    end else if (wb_en) begin
      wb_valid_r <= mem_valid_r;
      wb_addr_r  <= mem_addr_r;
      wb_wen_r   <= mem_wen_r;
    end
  end

  assign id_valid      = id_valid_r;
  assign exe_valid     = exe_valid_r;
  assign mem_valid     = mem_valid_r;
  assign wb_valid      = wb_valid_r;
  assign regw_addr_exe = exe_addr_r;
  assign regw_addr_mem = mem_addr_r;
  assign regw_addr_wb  = wb_addr_r;
  // Flags are qualified by the stage valid bit so a stale flag never leaks out
  assign wb_wen_exe    = exe_wen_r  & exe_valid_r;
  assign wb_wen_mem    = mem_wen_r  & mem_valid_r;
  assign wb_wen_wb     = wb_wen_r   & wb_valid_r;
  assign mem_ren_exe   = exe_ren_r  & exe_valid_r;
  assign mem_ren_mem   = mem_ren_r  & mem_valid_r;
  assign mem_wen_mem   = mem_mwen_r & mem_valid_r;
  assign is_branch_exe = exe_br_r   & exe_valid_r;
  assign is_branch_mem = mem_br_r   & mem_valid_r;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cycle_cnt_r, retire_cnt_r, stall_cnt_r;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_r  <= 32'd0;
      retire_cnt_r <= 32'd0;
      stall_cnt_r  <= 32'd0;
    end else begin
      if (cycle_cnt_r != 32'hFFFF_FFFF) begin
        cycle_cnt_r <= cycle_cnt_r + 32'd1;
      end
      if (wb_valid_r && wb_en && !wb_rst && (retire_cnt_r != 32'hFFFF_FFFF)) begin
        retire_cnt_r <= retire_cnt_r + 32'd1;
      end
      if (!id_en && exe_rst && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign cycle_cnt  = cycle_cnt_r;
  assign retire_cnt = retire_cnt_r;
  assign stall_cnt  = stall_cnt_r;
`else
  assign cycle_cnt  = 32'd0;
  assign retire_cnt = 32'd0;
  assign stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Self-checking bench for pipe_ctrl_regs: a stage-array model checked every cycle plus directed literal checks.
module tb_pipe_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst, if_valid;
  logic        id_en, id_rst, exe_en, exe_rst, mem_en, mem_rst, wb_en, wb_rst;
  logic        id_wb_wen, id_mem_ren, id_mem_wen, id_is_branch;
  logic [4:0]  id_regw_addr;
  logic        id_valid, exe_valid, mem_valid, wb_valid;
  logic [4:0]  regw_addr_exe, regw_addr_mem, regw_addr_wb;
  logic        wb_wen_exe, wb_wen_mem, wb_wen_wb, mem_ren_exe, mem_ren_mem, mem_wen_mem;
  logic        is_branch_exe, is_branch_mem;
  logic [31:0] cycle_cnt, retire_cnt, stall_cnt;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl_regs dut (
    .clk(clk), .rst(rst), .if_valid(if_valid),
    .id_en(id_en), .id_rst(id_rst), .exe_en(exe_en), .exe_rst(exe_rst),
    .mem_en(mem_en), .mem_rst(mem_rst), .wb_en(wb_en), .wb_rst(wb_rst),
    .id_wb_wen(id_wb_wen), .id_regw_addr(id_regw_addr), .id_mem_ren(id_mem_ren),
    .id_mem_wen(id_mem_wen), .id_is_branch(id_is_branch),
    .id_valid(id_valid), .exe_valid(exe_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb),
    .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb),
    .mem_ren_exe(mem_ren_exe), .mem_ren_mem(mem_ren_mem), .mem_wen_mem(mem_wen_mem),
    .is_branch_exe(is_branch_exe), .is_branch_mem(is_branch_mem),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  // Model: the pipeline is an array of 4 entries (0=ID .. 3=WB) that shift when enabled
  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
    logic       wen, ren, mwen, br;
  } ent_t;

  ent_t   m [4];
  ent_t   nm [4];
  longint mc_cyc, mc_ret, mc_stall, nc_cyc, nc_ret, nc_stall;

  function automatic longint sat_inc(input longint v);
    return (v >= 64'hFFFF_FFFF) ? v : v + 1;
  endfunction

  always_comb begin
    logic en [4];
    logic clr [4];
    en  = '{id_en, exe_en, mem_en, wb_en};
    clr = '{id_rst, exe_rst, mem_rst, wb_rst};
    for (int k = 0; k < 4; k++) begin
      nm[k] = m[k];
      if (rst || clr[k]) begin
        nm[k] = '0;
      end else if (en[k]) begin
        if (k == 0) begin
          nm[k] = '0;
          nm[k].valid = if_valid;
        end else if (k == 1) begin
          nm[k] = '{valid: m[0].valid, addr: id_regw_addr,
                    wen: id_wb_wen && (id_regw_addr != 5'd0),
                    ren: id_mem_ren, mwen: id_mem_wen, br: id_is_branch};
        end else begin
          nm[k] = m[k-1];
        end
      end
    end
    nc_cyc = mc_cyc;
    nc_ret = mc_ret;
    nc_stall = mc_stall;
    if (rst) begin
      nc_cyc = 0; nc_ret = 0; nc_stall = 0;
    end else begin
      nc_cyc = sat_inc(mc_cyc);
      if (m[3].valid && wb_en && !wb_rst) nc_ret = sat_inc(mc_ret);
      if (!id_en && exe_rst) nc_stall = sat_inc(mc_stall);
    end
  end

  always @(posedge clk) begin
    m        <= nm;
    mc_cyc   <= nc_cyc;
    mc_ret   <= nc_ret;
    mc_stall <= nc_stall;
  end

  task automatic check(input string nm_s, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm_s, act, exp, $time);
    end
  endtask

  // Compare every output against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("id_valid",      {31'd0, id_valid},      {31'd0, m[0].valid});
      check("exe_valid",     {31'd0, exe_valid},     {31'd0, m[1].valid});
      check("mem_valid",     {31'd0, mem_valid},     {31'd0, m[2].valid});
      check("wb_valid",      {31'd0, wb_valid},      {31'd0, m[3].valid});
      check("regw_addr_exe", {27'd0, regw_addr_exe}, {27'd0, m[1].addr});
      check("regw_addr_mem", {27'd0, regw_addr_mem}, {27'd0, m[2].addr});
      check("regw_addr_wb",  {27'd0, regw_addr_wb},  {27'd0, m[3].addr});
      check("wb_wen_exe",    {31'd0, wb_wen_exe},    {31'd0, m[1].wen  & m[1].valid});
      check("wb_wen_mem",    {31'd0, wb_wen_mem},    {31'd0, m[2].wen  & m[2].valid});
      check("wb_wen_wb",     {31'd0, wb_wen_wb},     {31'd0, m[3].wen  & m[3].valid});
      check("mem_ren_exe",   {31'd0, mem_ren_exe},   {31'd0, m[1].ren  & m[1].valid});
      check("mem_ren_mem",   {31'd0, mem_ren_mem},   {31'd0, m[2].ren  & m[2].valid});
      check("mem_wen_mem",   {31'd0, mem_wen_mem},   {31'd0, m[2].mwen & m[2].valid});
      check("is_branch_exe", {31'd0, is_branch_exe}, {31'd0, m[1].br   & m[1].valid});
      check("is_branch_mem", {31'd0, is_branch_mem}, {31'd0, m[2].br   & m[2].valid});
      check("cycle_cnt",  cycle_cnt,  PERF ? mc_cyc[31:0]   : 32'd0);
      check("retire_cnt", retire_cnt, PERF ? mc_ret[31:0]   : 32'd0);
      check("stall_cnt",  stall_cnt,  PERF ? mc_stall[31:0] : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic v);
    id_en = v; exe_en = v; mem_en = v; wb_en = v;
    id_rst = 1'b0; exe_rst = 1'b0; mem_rst = 1'b0; wb_rst = 1'b0;
  endtask

  task automatic decode(input logic wen, input logic [4:0] addr, input logic ren,
                        input logic mwen, input logic br);
    id_wb_wen = wen; id_regw_addr = addr; id_mem_ren = ren; id_mem_wen = mwen; id_is_branch = br;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0;
    set_en(1'b0);
    decode(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    m = '{default: '0};
    mc_cyc = 0; mc_ret = 0; mc_stall = 0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_addr_wb",  {27'd0, regw_addr_wb}, 32'd0);
    check("rst_cycle",    cycle_cnt, 32'd0);

    // Idle after reset: outputs stay zero even with decode inputs wiggling
    decode(1'b1, 5'd9, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    check("idle_exe_valid", {31'd0, exe_valid}, 32'd0);

    // Basic latency with a write to r5
    set_en(1'b1); if_valid = 1'b1;
    decode(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    decode(1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    check("lat_addr_exe", {27'd0, regw_addr_exe}, 32'd5);
    check("lat_wen_exe",  {31'd0, wb_wen_exe}, 32'd1);
    decode(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("lat_addr_mem", {27'd0, regw_addr_mem}, 32'd5);
    check("lat_wen_mem",  {31'd0, wb_wen_mem}, 32'd1);
    check("br_exe",       {31'd0, is_branch_exe}, 32'd1);
    tick();
    check("lat_wen_wb",   {31'd0, wb_wen_wb}, 32'd1);
    check("lat_addr_wb",  {27'd0, regw_addr_wb}, 32'd5);

    // Write to r0 is valid but not enabled
    decode(1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("r0_wen_exe", {31'd0, wb_wen_exe}, 32'd0);
    check("r0_valid",   {31'd0, exe_valid}, 32'd1);

    // Load-use stall bubble
    decode(1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    check("lw_ren_exe", {31'd0, mem_ren_exe}, 32'd1);
    id_en = 1'b0; exe_rst = 1'b1; if_valid = 1'b0;
    decode(1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
    tick();
    check("stall_exe_valid", {31'd0, exe_valid}, 32'd0);
    check("stall_exe_addr",  {27'd0, regw_addr_exe}, 32'd0);
    check("stall_ren_mem",   {31'd0, mem_ren_mem}, 32'd1);
    check("stall_addr_mem",  {27'd0, regw_addr_mem}, 32'd8);
    check("stall_id_held",   {31'd0, id_valid}, 32'd1);
    set_en(1'b1); if_valid = 1'b1;

    // Clear beats enable on MEM
    decode(1'b1, 5'd12, 1'b0, 1'b1, 1'b0);
    tick();
    check("clr_pre_exe", {31'd0, exe_valid}, 32'd1);
    mem_rst = 1'b1;
    tick();
    check("clr_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("clr_mem_addr",  {27'd0, regw_addr_mem}, 32'd0);
    mem_rst = 1'b0;

    // WB hold while MEM keeps changing
    decode(1'b1, 5'd20, 1'b0, 1'b0, 1'b0); tick();
    decode(1'b1, 5'd21, 1'b0, 1'b0, 1'b0); tick();
    decode(1'b1, 5'd22, 1'b0, 1'b0, 1'b0); tick();
    check("hold_pre_wb", {27'd0, regw_addr_wb}, 32'd20);
    wb_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      decode(1'b1, 5'(23 + i), 1'b0, 1'b0, 1'b0);
      tick();
      check("hold_addr_wb", {27'd0, regw_addr_wb}, 32'd20);
      check("hold_wen_wb",  {31'd0, wb_wen_wb}, 32'd1);
    end
    check("hold_addr_mem", {27'd0, regw_addr_mem}, 32'd24);
    wb_en = 1'b1;

    // Counter scenario: 10 cycles, stalls on cycles 2 and 3, 4 retirements
    rst = 1'b1; tick(); rst = 1'b0;
    check("cnt_rst_cycle", cycle_cnt, 32'd0);
    check("cnt_rst_valid", {31'd0, exe_valid}, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      set_en(1'b1); if_valid = 1'b1;
      if (i == 2 || i == 3) begin
        id_en = 1'b0; exe_rst = 1'b1;
      end
      decode(1'b1, 5'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_en(1'b1);
    check("cnt_cycle",  cycle_cnt,  PERF ? 32'd10 : 32'd0);
    check("cnt_stall",  stall_cnt,  PERF ? 32'd2  : 32'd0);
    check("cnt_retire", retire_cnt, PERF ? 32'd4  : 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_cycle",  cycle_cnt,  32'd0);
    check("midrst_retire", retire_cnt, 32'd0);
    check("midrst_stall",  stall_cnt,  32'd0);
    check("midrst_wb",     {31'd0, wb_valid}, 32'd0);
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
